// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Imported by the hazard controller and the forwarding unit.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Encoding order equals priority: a higher value wins.
    typedef enum logic [1:0] {
        HZ_NONE     = 2'd0,
        HZ_LOAD_USE = 2'd1,
        HZ_BRANCH   = 2'd2,
        HZ_HOLD     = 2'd3
    } haz_e;

endpackage

// File: rtl/fwd_unit.sv
// ALU operand forwarding select for one source register.
// The MEM stage result is newer than WB, so it wins.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_mem,
    input  logic       regwrite_mem,
    input  logic [4:0] rd_wb,
    input  logic       regwrite_wb,
    output logic [1:0] sel
);

    logic hit_mem;
    logic hit_wb;

    assign hit_mem = regwrite_mem && (rd_mem != 5'd0) && (rd_mem == rs);
    assign hit_wb  = regwrite_wb && (rd_wb != 5'd0) && (rd_wb == rs);

    always_comb begin
        sel = FWD_RF;
        if (hit_mem) begin
            sel = FWD_MEM;
        end else if (hit_wb) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline, with
// a fixed-latency data-memory wait FSM and saturating perf counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic [4:0]       rs_ex,
    input  logic [4:0]       rt_ex,
    input  logic [4:0]       rd_ex,
    input  logic             memread_ex,
    input  logic             regwrite_ex,
    input  logic [4:0]       rd_mem,
    input  logic             regwrite_mem,
    input  logic             memread_mem,
    input  logic             memwrite_mem,
    input  logic             branch_mem,
    input  logic             zero_mem,
    input  logic [4:0]       rd_wb,
    input  logic             regwrite_wb,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = 5;
    localparam bit MULTI  = (MEM_LAT > 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT =
        WAIT_W'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic       mem_op;
    logic       hold;
    logic       taken;
    logic       load_use;
    haz_e       haz;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    assign mem_op = memread_mem | memwrite_mem;
    assign hold   = (state_q == RUN && mem_op && MULTI)
                 || (state_q == MEMWAIT && wait_q != '0);
    assign taken  = branch_mem & zero_mem;
    assign load_use = memread_ex && regwrite_ex && (rd_ex != 5'd0)
                   && ((rd_ex == rs_id) || (rd_ex == rt_id));

    always_comb begin
        haz = HZ_NONE;
        if (hold) begin
            haz = HZ_HOLD;
        end else if (taken) begin
            haz = HZ_BRANCH;
        end else if (load_use) begin
            haz = HZ_LOAD_USE;
        end
    end

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_bubble = 1'b0;
        unique case (haz)
            HZ_HOLD: begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_en     = 1'b0;
                memwb_bubble = 1'b1;
            end
            HZ_BRANCH: begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end
            HZ_LOAD_USE: begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
            default: ;
        endcase
        // Reset overrides everything so the pipe fills with bubbles.
        if (!rst_n) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            memwb_bubble = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            RUN: begin
                if (mem_op && MULTI) begin
                    state_d = MEMWAIT;
                    wait_d  = WAIT_INIT;
                end
            end
            MEMWAIT: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (haz == HZ_BRANCH && flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    fwd_unit u_fwd_a (
        .rs           (rs_ex),
        .rd_mem       (rd_mem),
        .regwrite_mem (regwrite_mem),
        .rd_wb        (rd_wb),
        .regwrite_wb  (regwrite_wb),
        .sel          (sel_a)
    );

    fwd_unit u_fwd_b (
        .rs           (rt_ex),
        .rd_mem       (rd_mem),
        .regwrite_mem (regwrite_mem),
        .rd_wb        (rd_wb),
        .regwrite_wb  (regwrite_wb),
        .sel          (sel_b)
    );

    assign fwd_a     = rst_n ? sel_a : FWD_RF;
    assign fwd_b     = rst_n ? sel_b : FWD_RF;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector scoreboard bench for pipe_hazard_ctrl
// (MEM_LAT=3, CNT_W=4).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs_id, rt_id, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb;
    logic       memread_ex, regwrite_ex, regwrite_mem;
    logic       memread_mem, memwrite_mem, branch_mem, zero_mem;
    logic       regwrite_wb;
    logic       pc_en, ifid_en, idex_en, exmem_en;
    logic       ifid_flush, idex_flush, exmem_flush, memwb_bubble;
    logic [1:0] fwd_a, fwd_b;
    logic [3:0] stall_cnt, flush_cnt;

    // {pc,ifid,idex,exmem en ; ifid,idex,exmem flush, memwb_bubble}
    localparam logic [7:0] C_RUN  = 8'b1111_0000;
    localparam logic [7:0] C_RST  = 8'b0000_1111;
    localparam logic [7:0] C_HOLD = 8'b0000_0001;
    localparam logic [7:0] C_LU   = 8'b0011_0100;
    localparam logic [7:0] C_BR   = 8'b1111_1110;

    string       q_name[$];
    logic [19:0] q_exp[$];
    int          total_cnt = 0;
    int          pass_cnt  = 0;

    pipe_hazard_ctrl #(.MEM_LAT(3), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_id(rs_id), .rt_id(rt_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
        .rd_ex(rd_ex), .memread_ex(memread_ex), .regwrite_ex(regwrite_ex),
        .rd_mem(rd_mem), .regwrite_mem(regwrite_mem),
        .memread_mem(memread_mem), .memwrite_mem(memwrite_mem),
        .branch_mem(branch_mem), .zero_mem(zero_mem),
        .rd_wb(rd_wb), .regwrite_wb(regwrite_wb),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .memwb_bubble(memwb_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry is consumed per falling edge.
    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            string       nm;
            logic [19:0] e;
            logic [19:0] a;
            nm = q_name.pop_front();
            e  = q_exp.pop_front();
            a  = {pc_en, ifid_en, idex_en, exmem_en,
                  ifid_flush, idex_flush, exmem_flush, memwb_bubble,
                  fwd_a, fwd_b, stall_cnt, flush_cnt};
            total_cnt++;
            if (a === e) begin
                pass_cnt++;
            end else begin
                $display("FAIL %s: got %b_%b_%b_%h_%h required %b_%b_%b_%h_%h",
                         nm, a[19:12], a[11:10], a[9:8], a[7:4], a[3:0],
                         e[19:12], e[11:10], e[9:8], e[7:4], e[3:0]);
            end
        end
    end

    task automatic expect_out(input string nm, input logic [7:0] c,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input int sc, input int fc);
        q_name.push_back(nm);
        q_exp.push_back({c, fa, fb, 4'(sc), 4'(fc)});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rs_id = 0; rt_id = 0; rs_ex = 0; rt_ex = 0; rd_ex = 0;
        rd_mem = 0; rd_wb = 0;
        memread_ex = 0; regwrite_ex = 0; regwrite_mem = 0;
        memread_mem = 0; memwrite_mem = 0;
        branch_mem = 0; zero_mem = 0; regwrite_wb = 0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs,
                          input logic [4:0] rt);
        memread_ex = 1; regwrite_ex = 1;
        rd_ex = rd; rs_id = rs; rt_id = rt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        clr();
        cyc();
        expect_out("reset", C_RST, 2'b00, 2'b00, 0, 0);
        cyc();
        rst_n = 1'b1;

        expect_out("idle", C_RUN, 2'b00, 2'b00, 0, 0);
        cyc();
        set_lu(5, 5, 0);
        expect_out("load_use_rs", C_LU, 2'b00, 2'b00, 0, 0);
        cyc();
        clr();
        expect_out("load_use_clear", C_RUN, 2'b00, 2'b00, 1, 0);
        cyc();
        set_lu(0, 0, 0);
        expect_out("load_use_r0", C_RUN, 2'b00, 2'b00, 1, 0);
        cyc();
        set_lu(9, 0, 9);
        expect_out("load_use_rt", C_LU, 2'b00, 2'b00, 1, 0);
        cyc();
        set_lu(9, 0, 9);
        regwrite_ex = 0;
        expect_out("load_no_regwrite", C_RUN, 2'b00, 2'b00, 2, 0);
        cyc();

        clr();
        set_lu(5, 5, 0);
        branch_mem = 1; zero_mem = 1;
        expect_out("branch_over_lu", C_BR, 2'b00, 2'b00, 2, 0);
        cyc();
        clr();
        branch_mem = 1;
        expect_out("branch_not_taken", C_RUN, 2'b00, 2'b00, 2, 1);
        cyc();

        clr();
        memread_mem = 1;
        expect_out("memwait_0", C_HOLD, 2'b00, 2'b00, 2, 1);
        cyc();
        branch_mem = 1; zero_mem = 1;
        expect_out("memwait_1_branch", C_HOLD, 2'b00, 2'b00, 3, 1);
        cyc();
        expect_out("memwait_release", C_BR, 2'b00, 2'b00, 4, 1);
        cyc();
        clr();
        expect_out("memwait_done", C_RUN, 2'b00, 2'b00, 4, 2);
        cyc();

        rd_mem = 7; rd_wb = 7; regwrite_mem = 1; regwrite_wb = 1;
        rs_ex = 7; rt_ex = 7;
        expect_out("fwd_mem_prio", C_RUN, 2'b10, 2'b10, 4, 2);
        cyc();
        regwrite_mem = 0;
        expect_out("fwd_wb", C_RUN, 2'b01, 2'b01, 4, 2);
        cyc();
        regwrite_mem = 1;
        rd_mem = 0; rd_wb = 0; rs_ex = 0; rt_ex = 0;
        expect_out("fwd_r0", C_RUN, 2'b00, 2'b00, 4, 2);
        cyc();
        rs_ex = 7; rt_ex = 3; rd_mem = 3; rd_wb = 7;
        expect_out("fwd_split", C_RUN, 2'b01, 2'b10, 4, 2);
        cyc();

        clr();
        memwrite_mem = 1;
        expect_out("store_wait", C_HOLD, 2'b00, 2'b00, 4, 2);
        cyc();
        rst_n = 1'b0;
        rs_ex = 7; rd_mem = 7; regwrite_mem = 1;
        #1;
        expect_out("reset_async", C_RST, 2'b00, 2'b00, 0, 0);
        cyc();
        expect_out("reset_held", C_RST, 2'b00, 2'b00, 0, 0);
        cyc();
        rst_n = 1'b1;
        clr();
        memwrite_mem = 1;
        expect_out("post_reset_run", C_HOLD, 2'b00, 2'b00, 0, 0);
        cyc();
        expect_out("post_reset_wait", C_HOLD, 2'b00, 2'b00, 1, 0);
        cyc();
        memwrite_mem = 0;
        expect_out("post_reset_rel", C_RUN, 2'b00, 2'b00, 2, 0);
        cyc();

        set_lu(4, 4, 0);
        for (int i = 0; i < 20; i++) begin
            expect_out($sformatf("stall_sat_%0d", i), C_LU, 2'b00, 2'b00,
                       (2 + i > 15) ? 15 : 2 + i, 0);
            cyc();
        end
        clr();
        expect_out("stall_sat_end", C_RUN, 2'b00, 2'b00, 15, 0);
        cyc();

        repeat (3) @(negedge clk);
        #1;
        if (q_exp.size() != 0) begin
            total_cnt++;
            $display("FAIL drain: %0d entries left, required 0",
                     q_exp.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
